axis_video_pad: RTL and testbench

- Inverse of the crop block: places a VIDEO_IN_W x VIDEO_IN_H AXI4-Stream video frame into a larger VIDEO_OUT_W x VIDEO_OUT_H canvas at (H_OFFSET, V_OFFSET).
- Fills the surrounding border with a constant PAD_VALUE.
- Sits after the crop/processing chain, ahead of the VDMA/display output. Restores full-raster timing for downstream consumers.

---
 rtl/axis_video_pkg.sv | 30 +++
 rtl/axis_video_raster_cnt.sv | 41 ++++
 rtl/axis_video_pad.sv | 153 +++++++++++++++
 tb/tb_axis_video_pad.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_video_pkg.sv
// Shared definitions for the AXI4-Stream video raster blocks (crop / pad).
package axis_video_pkg;

   localparam int unsigned PTR_W   = 16;
   localparam int unsigned SOF_BIT = 0;

   // Frame state encoding
   localparam logic [0:0] ST_WAIT_SOF = 1'b0;
   localparam logic [0:0] ST_ACTIVE   = 1'b1;

   // True when lo <= pos < lo+len; sum is widened so lo+len never wraps
   function automatic logic in_span(input logic [PTR_W-1:0] pos,
                                    input logic [PTR_W-1:0] lo,
                                    input logic [PTR_W-1:0] len);
      logic [PTR_W:0] hi;
      hi = {1'b0, lo} + {1'b0, len};
      return (pos >= lo) && ({1'b0, pos} < hi);
   endfunction

   // Rectangular window hit test on a (column, line) raster position
   function automatic logic win_hit(input logic [PTR_W-1:0] hor,
                                    input logic [PTR_W-1:0] ver,
                                    input logic [PTR_W-1:0] h_lo,
                                    input logic [PTR_W-1:0] h_len,
                                    input logic [PTR_W-1:0] v_lo,
                                    input logic [PTR_W-1:0] v_len);
      return in_span(hor, h_lo, h_len) && in_span(ver, v_lo, v_len);
   endfunction

endpackage

// File: rtl/axis_video_raster_cnt.sv
// Output raster position counter: column/line with wrap and end-of-frame flag.
module axis_video_raster_cnt
   import axis_video_pkg::*;
#(
   parameter int unsigned OUT_W = 1920,
   parameter int unsigned OUT_H = 1080
) (
   input  logic             axis_clk,
   input  logic             rst,
   input  logic             adv,
   output logic [PTR_W-1:0] hor_ptr,
   output logic [PTR_W-1:0] ver_ptr,
   output logic             last_col_c,
   output logic             eof_c
);

   logic last_row;

   // Position flags decoded from the current counters
   always_comb begin
      last_col_c = (hor_ptr == PTR_W'(OUT_W - 1));
      last_row   = (ver_ptr == PTR_W'(OUT_H - 1));
      eof_c      = last_col_c && last_row;
   end

   // Advance one pixel; wrap column into next line, wrap line at frame end
   always_ff @(posedge axis_clk) begin
      if (rst) begin
         hor_ptr <= '0;
         ver_ptr <= '0;
      end else if (adv) begin
         if (last_col_c) begin
            hor_ptr <= '0;
            ver_ptr <= last_row ? '0 : ver_ptr + PTR_W'(1);
         end else begin
            hor_ptr <= hor_ptr + PTR_W'(1);
         end
      end
   end

endmodule

// File: rtl/axis_video_pad.sv
// Places an input video frame into a larger canvas, filling the border with a constant.
module axis_video_pad
   import axis_video_pkg::*;
#(
   parameter int unsigned          VIDEO_IN_W  = 640,
   parameter int unsigned          VIDEO_IN_H  = 480,
   parameter int unsigned          VIDEO_OUT_W = 1920,
   parameter int unsigned          VIDEO_OUT_H = 1080,
   parameter int unsigned          H_OFFSET    = 640,
   parameter int unsigned          V_OFFSET    = 300,
   parameter int unsigned          DATA_WIDTH  = 24,
   parameter int unsigned          USER_WIDTH  = 1,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
   input  logic                  axis_clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   output logic [15:0]           hor_ptr,
   output logic [15:0]           ver_ptr,
   output logic                  err_eol,
   output logic                  err_sof,
   output logic                  frame_done
);

   // Parameter sanity checks at elaboration
   if (H_OFFSET + VIDEO_IN_W > VIDEO_OUT_W) begin : g_bad_h
      $error("axis_video_pad: H_OFFSET+VIDEO_IN_W exceeds VIDEO_OUT_W");
   end
   if (V_OFFSET + VIDEO_IN_H > VIDEO_OUT_H) begin : g_bad_v
      $error("axis_video_pad: V_OFFSET+VIDEO_IN_H exceeds VIDEO_OUT_H");
   end
   if (VIDEO_IN_W > 65535 || VIDEO_IN_H > 65535 ||
       VIDEO_OUT_W > 65535 || VIDEO_OUT_H > 65535 ||
       H_OFFSET > 65535 || V_OFFSET > 65535) begin : g_bad_dim
      $error("axis_video_pad: dimensions must be below 65536");
   end

   logic [0:0] state_q;
   logic [0:0] state_d;
   logic       load_en;
   logic       in_win;
   logic       adv;
   logic       consume;
   logic       last_col;
   logic       eof;
   logic       m_last_pix_q;

   axis_video_raster_cnt #(
      .OUT_W (VIDEO_OUT_W),
      .OUT_H (VIDEO_OUT_H)
   ) u_cnt (
      .axis_clk   (axis_clk),
      .rst        (rst),
      .adv        (adv),
      .hor_ptr    (hor_ptr),
      .ver_ptr    (ver_ptr),
      .last_col_c (last_col),
      .eof_c      (eof)
   );

   // Output slot free and window membership of the current raster position
   always_comb begin
      load_en = !m_axis_tvalid || m_axis_tready;
      in_win  = win_hit(hor_ptr, ver_ptr,
                        PTR_W'(H_OFFSET), PTR_W'(VIDEO_IN_W),
                        PTR_W'(V_OFFSET), PTR_W'(VIDEO_IN_H));
   end

   // Next state, input ready and raster advance
   always_comb begin
      state_d       = state_q;
      s_axis_tready = 1'b0;
      adv           = 1'b0;
      consume       = 1'b0;
      case (state_q)
         ST_WAIT_SOF: begin
            // Non-SOF beats are swallowed; the SOF beat stays for the window
            s_axis_tready = !s_axis_tuser[SOF_BIT] && !rst;
            if (s_axis_tvalid && s_axis_tuser[SOF_BIT]) begin
               state_d = ST_ACTIVE;
            end
         end
         default: begin
            if (in_win) begin
               s_axis_tready = load_en && !rst;
               consume       = s_axis_tvalid && s_axis_tready;
               adv           = consume;
            end else begin
               adv = load_en;
            end
            if (adv && eof) begin
               state_d = ST_WAIT_SOF;
            end
         end
      endcase
   end

   // State register
   always_ff @(posedge axis_clk) begin
      if (rst) begin
         state_q <= ST_WAIT_SOF;
      end else begin
         state_q <= state_d;
      end
   end

   // Single output register stage; a beat is loaded whenever the raster advances
   always_ff @(posedge axis_clk) begin
      if (rst) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= '0;
         m_last_pix_q  <= 1'b0;
      end else if (load_en) begin
         m_axis_tvalid <= adv;
         if (adv) begin
            m_axis_tdata <= in_win ? s_axis_tdata : PAD_VALUE;
            m_axis_tlast <= last_col;
            m_axis_tuser <= USER_WIDTH'(hor_ptr == '0 && ver_ptr == '0);
            m_last_pix_q <= eof;
         end
      end
   end

   // Input framing error pulses, aligned with the output beat they belong to
   always_ff @(posedge axis_clk) begin
      if (rst) begin
         err_eol <= 1'b0;
         err_sof <= 1'b0;
      end else begin
         err_eol <= consume &&
                    (s_axis_tlast != (hor_ptr == PTR_W'(H_OFFSET + VIDEO_IN_W - 1)));
         err_sof <= consume && s_axis_tuser[SOF_BIT] &&
                    !(hor_ptr == PTR_W'(H_OFFSET) && ver_ptr == PTR_W'(V_OFFSET));
      end
   end

   // Frame completion coincides with the downstream handshake of the last pixel
   always_comb begin
      frame_done = !rst && m_axis_tvalid && m_axis_tready && m_last_pix_q;
   end

endmodule

// File: tb/tb_axis_video_pad.sv
// Directed bench for axis_video_pad on a small 4x2-into-8x4 canvas.
module tb_axis_video_pad;

   localparam int IW = 4;
   localparam int IH = 2;
   localparam int OW = 8;
   localparam int OH = 4;
   localparam int HO = 2;
   localparam int VO = 1;
   localparam int NB = OW * OH;

   logic        axis_clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic [0:0]  s_axis_tuser = '0;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic [0:0]  m_axis_tuser;
   logic [15:0] hor_ptr;
   logic [15:0] ver_ptr;
   logic        err_eol;
   logic        err_sof;
   logic        frame_done;

   int errors = 0;
   int checks = 0;
   int eol_hi, eol_rise, sof_hi;
   logic prev_eol;
   int got;

   always #5 axis_clk = ~axis_clk;

   axis_video_pad #(
      .VIDEO_IN_W (IW), .VIDEO_IN_H (IH),
      .VIDEO_OUT_W(OW), .VIDEO_OUT_H(OH),
      .H_OFFSET   (HO), .V_OFFSET   (VO),
      .DATA_WIDTH (8),  .USER_WIDTH (1),
      .PAD_VALUE  (8'h00)
   ) dut (
      .axis_clk     (axis_clk),
      .rst          (rst),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tuser (s_axis_tuser),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .m_axis_tuser (m_axis_tuser),
      .hor_ptr      (hor_ptr),
      .ver_ptr      (ver_ptr),
      .err_eol      (err_eol),
      .err_sof      (err_sof),
      .frame_done   (frame_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Canvas pixel k: window pixels numbered 1..IW*IH in raster order, border 0
   function automatic logic [7:0] exp_pix(input int k);
      int line, col;
      line = k / OW;
      col  = k % OW;
      if (line >= VO && line < VO + IH && col >= HO && col < HO + IW)
         return 8'((line - VO) * IW + (col - HO) + 1);
      return 8'h00;
   endfunction

   task automatic send_beat(input logic [7:0] d, input logic sof, input logic last);
      logic hs;
      hs = 1'b0;
      s_axis_tdata  = d;
      s_axis_tuser  = sof;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      for (int n = 0; n < 500 && !hs; n++) begin
         @(negedge axis_clk);
         hs = s_axis_tready;
         @(posedge axis_clk);
         #1;
      end
      check("s_handshake", 32'(hs), 32'd1);
   endtask

   // garbage: leading non-SOF beats; gap: idle cycles between pixels; bad_last: pixel index carrying early tlast
   task automatic drive_frame(input int garbage, input int gap, input int bad_last);
      logic last;
      for (int g = 0; g < garbage; g++) send_beat(8'(8'hE0 + g), 1'b0, 1'b0);
      for (int i = 0; i < IW * IH; i++) begin
         if (i > 0) begin
            for (int q = 0; q < gap; q++) begin
               s_axis_tvalid = 1'b0;
               @(posedge axis_clk);
               #1;
            end
         end
         if (bad_last >= 0) last = (i == bad_last) || (i == IW * IH - 1);
         else               last = ((i % IW) == IW - 1);
         send_beat(8'(i + 1), i == 0, last);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = '0;
      s_axis_tlast  = 1'b0;
   endtask

   // mode 0: sink always ready; mode 1: ready pattern 1,0,0,1
   task automatic collect(input int mode, input int nbeats, output int n_got);
      logic held;
      logic [7:0] held_d;
      int cyc;
      held = 1'b0;
      held_d = '0;
      cyc = 0;
      n_got = 0;
      while (n_got < nbeats && cyc < 2000) begin
         m_axis_tready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         @(negedge axis_clk);
         if (err_eol && !prev_eol) eol_rise++;
         if (err_eol) eol_hi++;
         if (err_sof) sof_hi++;
         prev_eol = err_eol;
         if (held) begin
            check("hold_valid", 32'(m_axis_tvalid), 32'd1);
            check("hold_data", 32'(m_axis_tdata), 32'(held_d));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            check($sformatf("data[%0d]", n_got), 32'(m_axis_tdata), 32'(exp_pix(n_got)));
            check($sformatf("tuser[%0d]", n_got), 32'(m_axis_tuser), 32'(n_got == 0));
            check($sformatf("tlast[%0d]", n_got), 32'(m_axis_tlast), 32'((n_got % OW) == OW - 1));
            check($sformatf("frame_done[%0d]", n_got), 32'(frame_done), 32'(n_got == NB - 1));
            n_got++;
         end
         held   = m_axis_tvalid && !m_axis_tready;
         held_d = m_axis_tdata;
         @(posedge axis_clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run_frame(input int garbage, input int gap, input int bad_last,
                            input int mode, input int exp_eol_hi, input int exp_eol_rise);
      int n;
      eol_hi = 0; eol_rise = 0; sof_hi = 0; prev_eol = 1'b0;
      fork
         drive_frame(garbage, gap, bad_last);
         collect(mode, NB, n);
      join
      check("beat_count", 32'(n), 32'(NB));
      check("err_eol_cycles", 32'(eol_hi), 32'(exp_eol_hi));
      check("err_eol_pulses", 32'(eol_rise), 32'(exp_eol_rise));
      check("err_sof_cycles", 32'(sof_hi), 32'd0);
      m_axis_tready = 1'b1;
      repeat (2) @(posedge axis_clk);
      @(negedge axis_clk);
      check("idle_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("idle_wait_sof_ready", 32'(s_axis_tready), 32'd1);
      check("idle_hor", 32'(hor_ptr), 32'd0);
      check("idle_ver", 32'(ver_ptr), 32'd0);
      @(posedge axis_clk);
      #1;
   endtask

   initial begin
      // Reset values
      rst = 1'b1;
      repeat (3) @(posedge axis_clk);
      @(negedge axis_clk);
      check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
      check("rst_m_tuser", 32'(m_axis_tuser), 32'd0);
      check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
      check("rst_s_tready", 32'(s_axis_tready), 32'd0);
      check("rst_hor", 32'(hor_ptr), 32'd0);
      check("rst_ver", 32'(ver_ptr), 32'd0);
      check("rst_err_eol", 32'(err_eol), 32'd0);
      check("rst_err_sof", 32'(err_sof), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      @(posedge axis_clk);
      #1;
      rst = 1'b0;

      // Back-to-back frame, sink always ready
      run_frame(0, 0, -1, 0, 0, 0);
      // Garbage beats ahead of SOF are swallowed
      run_frame(3, 0, -1, 0, 0, 0);
      // Sink backpressure 1,0,0,1
      run_frame(0, 0, -1, 1, 0, 0);
      // Two idle input cycles between window pixels
      run_frame(0, 2, -1, 0, 0, 0);
      // tlast moved from pixel 4 to pixel 3: both mismatch back-to-back, one two-cycle pulse
      run_frame(0, 0, 2, 0, 2, 1);

      // Reset after output beat 12, then a clean frame
      eol_hi = 0; eol_rise = 0; sof_hi = 0; prev_eol = 1'b0;
      fork
         drive_frame(0, 0, -1);
         begin
            collect(0, 13, got);
            check("pre_rst_beats", 32'(got), 32'd13);
            rst = 1'b1;
            @(negedge axis_clk);
            check("rst_mid_s_tready", 32'(s_axis_tready), 32'd0);
            @(posedge axis_clk);
            #1;
            rst = 1'b0;
            @(negedge axis_clk);
            check("rst_mid_m_tvalid", 32'(m_axis_tvalid), 32'd0);
            check("rst_mid_hor", 32'(hor_ptr), 32'd0);
            check("rst_mid_ver", 32'(ver_ptr), 32'd0);
            check("rst_mid_frame_done", 32'(frame_done), 32'd0);
            @(posedge axis_clk);
            #1;
         end
      join
      repeat (2) @(posedge axis_clk);
      #1;
      run_frame(0, 0, -1, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
